mod_dec_inv_subbytes: RTL and testbench
=======================================

// Module: mod_dec_inv_subbytes
// PURPOSE
//  Decryption-path InvSubBytes engine for the AES-256 core. It maps a 128-bit state
//  through the inverse Rijndael S-box, one byte at a time. Each byte is computed
//  arithmetically rather than from a table: inverse affine transform, then GF(2^8)
//  inversion (x^254) by iterated square-and-multiply. It sits between the InvShiftRows
//  and AddRoundKey stages and uses valid/ready handshakes on both sides.
// PARAMETERS
//  data_width   8    byte width; fixed at 8, any other value is unsupported
//  NBYTES       16   bytes per state block; 128-bit state = NBYTES*data_width
//  ITER         7    square-and-multiply cycles per byte; fixed, since x^254 needs 7
// PORTS
//  clk        in   1    rising-edge clock
//  resetn     in   1    asynchronous active-low reset
//  in_valid   in   1    in_data holds a state block to transform
//  in_ready   out  1    block can be accepted (high only in IDLE)
//  in_data    in   128  input state; byte 0 = [127:120], byte 15 = [7:0]
//  out_valid  out  1    out_data holds a completed InvSubBytes result
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  result, same byte order as in_data
//  busy       out  1    high in LOAD or CALC
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, out_valid=0, busy=0, out_data=0, byte idx=0,
//   cnt=0, sq=0, res=0. in_ready=1 once resetn deasserts.
//  Reset mid-operation: the block is discarded, nothing is output, and state returns
//   to IDLE immediately.
//  FSM states: IDLE, LOAD, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: when in_valid & in_ready at an edge, capture in_data into the state register.
//    Set idx=0 and go to LOAD. in_valid is ignored in every other state.
//  - LOAD: sq <= invaff(state[idx]); res <= 8'h01; cnt <= 0; go to CALC.
//  - CALC, one edge per iteration: sq <= sq^2; res <= res * sq^2; cnt <= cnt+1.
//    On the edge with cnt==ITER-1, the final product is written into state[idx], in place.
//    Then if idx==NBYTES-1 go to DONE, else idx <= idx+1 and go to LOAD.
//  - DONE: hold out_data stable. When out_ready=1 at an edge, go to IDLE.
//    A new block can be accepted no earlier than the following edge.
//  invaff(x) = rotl(x,1) ^ rotl(x,3) ^ rotl(x,6) ^ 8'h05.
//  GF(2^8) multiply and square are combinational, modulo x^8+x^4+x^3+x+1 (0x11B).
//  Input 0 needs no special case: invaff(0x63)=0x00, 0^254=0, so InvSbox(0x63)=0x00.
//  Latency: accept at edge E0; byte k occupies edges E0+1+8k .. E0+8+8k.
//   out_valid rises after edge E0+128.
//  Throughput: one block per at least 130 cycles, counting the out handshake and return to IDLE.
//  out_data is the state register at all times. It is only meaningful while out_valid=1;
//   during LOAD/CALC it shows partial in-place results.
//  Backpressure: out_valid and out_data hold indefinitely while out_ready=0.
//   out_ready is ignored outside DONE.
//  Simultaneous: in_valid=1 during DONE is not accepted. The source must hold in_valid
//   until it sees in_ready=1.
// TESTING
//  1. in_data=637c777bf26b6fc53001672bfed7ab76 -> out_data=000102030405060708090a0b0c0d0e0f.
//     out_valid rises exactly 128 edges after acceptance.
//  2. All bytes 00 -> every byte 52. All bytes 16 -> every byte ff.
//     All bytes ed -> every byte 53. All bytes 63 -> every byte 00.
//  3. Exhaustive check: sweep 16 blocks covering all 256 byte values and compare
//     against a behavioural inverse S-box. Also check Sbox->InvSbox round trip
//     via the encryption ROM model.
//  4. Backpressure: hold out_ready=0 for 50 cycles in DONE -> out_valid and out_data are
//     stable and in_ready=0. Pulse out_ready -> IDLE next edge, and in_ready=1.
//  5. Assert resetn=0 at edge E0+60 -> busy, out_valid and out_data are 0 immediately.
//     After release, a new block (test 1 vector) completes correctly.
//  6. Hold in_valid=1 continuously with 3 different blocks -> each is accepted only in IDLE.
//     Each result is correct and in order, and no block is lost or duplicated.

Source files
------------

// File: rtl/mod_dec_inv_subbytes_if.sv
// Block-level handshake bundle for the InvSubBytes engine.
// Input side: a valid/ready pair carrying a 128-bit state block into the engine.
// Output side: a valid/ready pair carrying the transformed block out of the engine.
// Handshake rule on both sides: a transfer happens on a rising clk edge where
// valid and ready are both 1. The source holds valid and data stable until that
// edge. Ready may be high or low independently of valid.
interface mod_dec_inv_subbytes_if #(
   parameter int WIDTH = 128
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Block source and result sink, seen from outside the engine.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   // The engine itself.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/mod_dec_inv_subbytes.sv
// Decryption-path InvSubBytes engine. Each byte of the 128-bit state goes through
// the inverse affine transform and then a GF(2^8) inversion computed as x^254 by
// seven square-and-multiply steps. Bytes are processed in place, byte 0 first.
// Byte 0 sits in [127:120], byte NBYTES-1 in [7:0].
module mod_dec_inv_subbytes #(
   parameter int data_width = 8,
   parameter int NBYTES     = 16,
   parameter int ITER       = 7
) (
   input  logic                        clk,
   input  logic                        resetn,
   mod_dec_inv_subbytes_if.slave       bus,
   output logic                        busy,
   output logic [1:0]                  state_dbg
);

   localparam int W  = NBYTES * data_width;
   localparam int IW = $clog2(NBYTES);
   localparam int CW = $clog2(ITER);

   localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [data_width-1:0] st [NBYTES];
   logic [IW-1:0]         idx;
   logic [CW-1:0]         cnt;
   logic [7:0]            sq;
   logic [7:0]            res;
   logic [7:0]            sq2;
   logic [7:0]            prod;
   logic                  last_iter;
   logic                  last_byte;
   logic [W-1:0]          flat;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      gf_mul = p;
   endfunction

   // Inverse of the Rijndael affine transform.
   function automatic logic [7:0] inv_aff(input logic [7:0] x);
      inv_aff = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   endfunction

   assign sq2       = gf_mul(sq, sq);
   assign prod      = gf_mul(res, sq2);
   assign last_iter = (cnt == CNT_LAST);
   assign last_byte = (idx == IDX_LAST);

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state logic: accept in IDLE, one LOAD plus ITER CALC edges per byte, hold in DONE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.in_valid)  state_nx = LOAD;
         LOAD:                    state_nx = CALC;
         CALC: if (last_iter)     state_nx = last_byte ? DONE : LOAD;
         DONE: if (bus.out_ready) state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // Datapath: capture block, then square-and-multiply each byte and write it back in place.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NBYTES; i++) st[i] <= '0;
         idx <= '0;
         cnt <= '0;
         sq  <= 8'h00;
         res <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < NBYTES; i++)
                     st[i] <= bus.in_data[(NBYTES-1-i)*data_width +: data_width];
                  idx <= '0;
               end
            end
            LOAD: begin
               sq  <= inv_aff(st[idx]);
               res <= 8'h01;
               cnt <= '0;
            end
            CALC: begin
               sq  <= sq2;
               res <= prod;
               cnt <= cnt + CW'(1);
               if (last_iter) begin
                  st[idx] <= prod;
                  if (!last_byte) idx <= idx + IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Present the state register as the output block, byte 0 in the top bits.
   always_comb begin
      flat = '0;
      for (int i = 0; i < NBYTES; i++)
         flat[(NBYTES-1-i)*data_width +: data_width] = st[i];
   end

   assign bus.out_data  = flat;
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign busy          = (state == LOAD) || (state == CALC);
   assign state_dbg     = state;

endmodule

// File: tb/tb_mod_dec_inv_subbytes.sv
// Bench for the InvSubBytes engine. The reference inverse S-box is built from the
// forward S-box definition (brute-force field inverse plus forward affine) and then
// inverted as a table.
module tb_mod_dec_inv_subbytes;

   logic       clk;
   logic       resetn;
   logic       busy;
   logic [1:0] state_dbg;

   int errors = 0;
   int checks = 0;

   logic [7:0]   sbox     [256];
   logic [7:0]   inv_sbox [256];
   logic [127:0] exp_q [$];

   localparam logic [127:0] VEC1_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] VEC1_OUT = 128'h000102030405060708090a0b0c0d0e0f;

   mod_dec_inv_subbytes_if #(.WIDTH(128)) ifc ();

   mod_dec_inv_subbytes dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (ifc),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      int pa, pb, r;
      pa = a; pb = b; r = 0;
      while (pb != 0) begin
         if (pb % 2 == 1) r = r ^ pa;
         pa = pa * 2;
         if (pa >= 256) pa = pa ^ 'h11b;
         pb = pb / 2;
      end
      return r[7:0];
   endfunction

   function automatic logic [7:0] m_rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   task automatic build_model();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox[x] = b ^ m_rotl(b, 1) ^ m_rotl(b, 2) ^ m_rotl(b, 3) ^ m_rotl(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) inv_sbox[sbox[x]] = 8'(x);
   endtask

   function automatic logic [127:0] model_inv(input logic [127:0] d);
      logic [127:0] r;
      for (int j = 0; j < 16; j++) r[(15-j)*8 +: 8] = inv_sbox[d[(15-j)*8 +: 8]];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   // Present d, wait for in_ready, return 1 time unit after the accepting edge.
   task automatic start_block(input logic [127:0] d, output bit ok);
      int guard;
      ok = 1'b0;
      @(negedge clk);
      ifc.in_data  = d;
      ifc.in_valid = 1'b1;
      guard = 0;
      while (!ifc.in_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (!ifc.in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", ifc.in_ready);
         ifc.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      ok = 1'b1;
   endtask

   // Count edges after the accepting edge until out_valid is seen.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!ifc.out_valid && lat < 400) begin
         @(posedge clk);
         lat++;
         #1;
      end
      if (!ifc.out_valid) begin
         checks++; errors++;
         $display("FAIL done_timeout: out_valid=%0b required 1", ifc.out_valid);
      end
   endtask

   task automatic ack_out();
      @(negedge clk);
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] d, output logic [127:0] q, output int lat);
      bit ok;
      q   = '0;
      lat = -1;
      start_block(d, ok);
      if (!ok) return;
      wait_done(lat);
      q = ifc.out_data;
      ack_out();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn        = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", ifc.out_valid); end
      checks++; if (ifc.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", ifc.out_data); end
      resetn = 1'b1;
      @(negedge clk);
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", ifc.in_ready); end
   endtask

   task automatic test_vector();
      logic [127:0] q;
      int lat;
      run_block(VEC1_IN, q, lat);
      checks++; if (q !== VEC1_OUT) begin errors++; $display("FAIL vec1_data: got %h want %h", q, VEC1_OUT); end
      checks++; if (lat !== 128) begin errors++; $display("FAIL vec1_latency: got %0d want 128", lat); end
      @(negedge clk);
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL vec1_idle: in_ready got %0b want 1", ifc.in_ready); end
   endtask

   task automatic test_uniform();
      logic [7:0]   ins  [4] = '{8'h00, 8'h16, 8'hed, 8'h63};
      logic [7:0]   outs [4] = '{8'h52, 8'hff, 8'h53, 8'h00};
      logic [127:0] q, want;
      int lat;
      for (int k = 0; k < 4; k++) begin
         want = {16{outs[k]}};
         run_block({16{ins[k]}}, q, lat);
         checks++;
         if (q !== want) begin errors++; $display("FAIL uniform_%h: got %h want %h", ins[k], q, want); end
      end
   endtask

   task automatic test_exhaustive();
      int perm [256];
      int j, t;
      logic [127:0] d, q, want;
      int lat;
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int b = 0; b < 16; b++) begin
         for (int k = 0; k < 16; k++) d[(15-k)*8 +: 8] = 8'(perm[b*16+k]);
         want = model_inv(d);
         run_block(d, q, lat);
         checks++;
         if (q !== want) begin errors++; $display("FAIL sweep_blk%0d: got %h want %h", b, q, want); end
      end
   endtask

   task automatic test_round_trip();
      logic [127:0] d, q, want;
      int lat;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 16; k++) begin
            want[(15-k)*8 +: 8] = 8'($urandom_range(0, 255));
            d[(15-k)*8 +: 8]    = sbox[want[(15-k)*8 +: 8]];
         end
         run_block(d, q, lat);
         checks++;
         if (q !== want) begin errors++; $display("FAIL round_trip_%0d: got %h want %h", r, q, want); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] d, want;
      bit ok;
      int lat, bad;
      for (int k = 0; k < 16; k++) d[(15-k)*8 +: 8] = 8'($urandom_range(0, 255));
      want = model_inv(d);
      start_block(d, ok);
      if (!ok) return;
      wait_done(lat);
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         ifc.in_valid = 1'b1;
         checks++;
         if (ifc.out_valid !== 1'b1 || ifc.out_data !== want || ifc.in_ready !== 1'b0) begin
            errors++;
            if (bad < 5)
               $display("FAIL bp_hold_c%0d: valid=%0b data=%h in_ready=%0b want 1 %h 0",
                        c, ifc.out_valid, ifc.out_data, ifc.in_ready, want);
            bad++;
         end
      end
      ifc.in_valid = 1'b0;
      ack_out();
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %0b want 1", ifc.in_ready); end
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %0b want 0", ifc.out_valid); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      start_block(VEC1_IN, ok);
      if (!ok) return;
      repeat (59) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b want 0", busy); end
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b want 0", ifc.out_valid); end
      checks++; if (ifc.out_data !== 128'h0) begin errors++; $display("FAIL midrst_out_data: got %h want 0", ifc.out_data); end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %0b want 0", ifc.out_valid); end
      test_vector();
   endtask

   task automatic test_back_to_back();
      logic [127:0] blk [3];
      int got;
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 16; k++) blk[b][(15-k)*8 +: 8] = 8'($urandom_range(0, 255));
         exp_q.push_back(model_inv(blk[b]));
      end
      got = 0;
      fork
         begin
            int guard;
            for (int b = 0; b < 3; b++) begin
               @(negedge clk);
               ifc.in_data  = blk[b];
               ifc.in_valid = 1'b1;
               guard = 0;
               while (!ifc.in_ready && guard < 1000) begin
                  @(negedge clk);
                  guard++;
               end
               @(posedge clk);
            end
            @(negedge clk);
            ifc.in_valid = 1'b0;
         end
         begin
            logic [127:0] want;
            for (int c = 0; c < 3000 && got < 3; c++) begin
               @(negedge clk);
               ifc.out_ready = 1'($urandom_range(0, 1));
               if (ifc.out_valid && ifc.out_ready) begin
                  want = exp_q.pop_front();
                  checks++;
                  if (ifc.out_data !== want) begin
                     errors++;
                     $display("FAIL b2b_blk%0d: got %h want %h", got, ifc.out_data, want);
                  end
                  got++;
               end
            end
            @(negedge clk);
            ifc.out_ready = 1'b0;
         end
      join
      checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got); end
      ifc.out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (ifc.out_valid) got++;
      end
      ifc.out_ready = 1'b0;
      checks++; if (got !== 0) begin errors++; $display("FAIL b2b_extra_output: got %0d cycles valid want 0", got); end
      exp_q.delete();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      build_model();
      test_reset();
      test_vector();
      test_uniform();
      test_exhaustive();
      test_round_trip();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

endmodule
